// File: rtl/fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// fpga_cfg_loader
//
// Streams the fabric configuration (routing, switch, logic-block and IO select
// vectors) from a word-wide source into a shadow chain. The shadow is copied
// to the active select outputs only after a trailing XOR checksum word matches.
// A failed or aborted load leaves the running configuration untouched.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             pulse: begin a load (honoured in IDLE/DONE/ERROR only)
//   abort             abandon the current load and go to ERROR
//   in_data/in_valid  configuration word stream
//   in_ready          loader accepts in_data (LOAD and CHECK states)
//   busy              load in progress (LOAD or CHECK)
//   done              last load committed
//   error             last load failed its checksum or was aborted
//   cfg_valid         active configuration committed at least once since reset
//   *select           active select vectors
// -----------------------------------------------------------------------------
module fpga_cfg_loader #(
  parameter int WORD_W = 8,
  parameter int BRB_W  = 750,
  parameter int BSB_W  = 1728,
  parameter int LB_W   = 80,
  parameter int IO_W   = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cfg_valid,
  output logic [BRB_W-1:0]  brbselect,
  output logic [BSB_W-1:0]  bsbselect,
  output logic [LB_W-1:0]   lbselect,
  output logic [IO_W-1:0]   leftioselect,
  output logic [IO_W-1:0]   rightioselect,
  output logic [IO_W-1:0]   topioselect,
  output logic [IO_W-1:0]   bottomioselect
);

  localparam int TOTAL    = BRB_W + BSB_W + LB_W + 4 * IO_W;
  localparam int NWORDS   = (TOTAL + WORD_W - 1) / WORD_W;
  localparam int SHADOW_W = NWORDS * WORD_W;
  localparam int CNT_W    = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SHADOW_W-1:0] shadow;
  logic [TOTAL-1:0]    active_cfg;
  logic [CNT_W-1:0]    word_cnt;
  logic [WORD_W-1:0]   csum;
  logic                xfer;
  logic                last_word;
  logic                start_load;
  logic                commit;

  // Status flags decode the state register directly, so in_ready never
  // depends on in_valid.
  assign in_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign busy     = in_ready;
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);

  // An abort in the same cycle drops the word, including a checksum word.
  assign xfer       = in_valid && in_ready && !abort;
  assign last_word  = (word_cnt == CNT_W'(NWORDS - 1));
  assign start_load = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                (state == ST_ERROR));
  assign commit     = (state == ST_CHECK) && xfer && (in_data == csum);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort has priority over every other event in a load
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)                  state_next = ST_ERROR;
        else if (xfer && last_word) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)     state_next = ST_ERROR;
        else if (xfer) state_next = (in_data == csum) ? ST_DONE : ST_ERROR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shadow chain: each word enters at the top and moves down one word slot
  // per transfer, so after NWORDS words stream bit k sits at shadow[k]. The
  // pad bits of the final word land above TOTAL and are never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      word_cnt <= '0;
      csum     <= '0;
    end else if (start_load) begin
      word_cnt <= '0;
      csum     <= '0;
    end else if ((state == ST_LOAD) && xfer) begin
      shadow   <= {in_data, shadow[SHADOW_W-1:WORD_W]};
      csum     <= csum ^ in_data;
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  // Active configuration changes only on the edge that enters DONE, so the
  // outputs never show a partially loaded image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_cfg <= '0;
      cfg_valid  <= 1'b0;
    end else if (commit) begin
      active_cfg <= shadow[TOTAL-1:0];
      cfg_valid  <= 1'b1;
    end
  end

  // Bit 0 of the stream is brbselect[0]; the last data bit is
  // bottomioselect[IO_W-1].
  assign brbselect      = active_cfg[BRB_W-1:0];
  assign bsbselect      = active_cfg[BRB_W +: BSB_W];
  assign lbselect       = active_cfg[BRB_W+BSB_W +: LB_W];
  assign leftioselect   = active_cfg[BRB_W+BSB_W+LB_W +: IO_W];
  assign rightioselect  = active_cfg[BRB_W+BSB_W+LB_W+IO_W +: IO_W];
  assign topioselect    = active_cfg[BRB_W+BSB_W+LB_W+2*IO_W +: IO_W];
  assign bottomioselect = active_cfg[BRB_W+BSB_W+LB_W+3*IO_W +: IO_W];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fpga_cfg_loader
//
// Self-checking bench for fpga_cfg_loader. A table of load vectors (pattern,
// checksum corruption, abort point, handshake duty) is applied in a loop; the
// expected outcome of every load is pushed to a scoreboard queue when its
// stimulus starts and popped when the checksum edge has passed. Reset and the
// mid-load reset case are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fpga_cfg_loader;

  localparam int WORD_W = 8;
  localparam int BRB_W  = 750;
  localparam int BSB_W  = 1728;
  localparam int LB_W   = 80;
  localparam int IO_W   = 30;
  localparam int TOTAL  = BRB_W + BSB_W + LB_W + 4 * IO_W;
  localparam int NWORDS = (TOTAL + WORD_W - 1) / WORD_W;
  localparam int BIG    = 4096;
  localparam int NVEC   = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              error;
  logic              cfg_valid;
  logic [BRB_W-1:0]  brbselect;
  logic [BSB_W-1:0]  bsbselect;
  logic [LB_W-1:0]   lbselect;
  logic [IO_W-1:0]   leftioselect;
  logic [IO_W-1:0]   rightioselect;
  logic [IO_W-1:0]   topioselect;
  logic [IO_W-1:0]   bottomioselect;

  fpga_cfg_loader #(
    .WORD_W(WORD_W), .BRB_W(BRB_W), .BSB_W(BSB_W), .LB_W(LB_W), .IO_W(IO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .error(error), .cfg_valid(cfg_valid),
    .brbselect(brbselect), .bsbselect(bsbselect), .lbselect(lbselect),
    .leftioselect(leftioselect), .rightioselect(rightioselect),
    .topioselect(topioselect), .bottomioselect(bottomioselect)
  );

  always #5 clk = ~clk;

  // pattern: 0 = word index mod 256, 1 = all ones (pads 0), 2 = all zeros
  typedef struct {
    int         pattern;
    logic [7:0] flip;
    int         abort_at;
    bit         gappy;
    bit         exp_done;
    bit         exp_error;
  } vec_t;

  typedef struct {
    bit               done;
    bit               error;
    bit               valid;
    logic [TOTAL-1:0] cfg;
  } exp_t;

  vec_t             vecs [NVEC];
  exp_t             sb[$];
  logic [TOTAL-1:0] model_cfg;
  bit               model_valid;
  int               n_cmp;
  int               n_fail;

  function automatic logic [WORD_W-1:0] gen_word(int pattern, int i);
    logic [WORD_W-1:0] w;
    w = '0;
    case (pattern)
      0: w = WORD_W'(i % 256);
      1: for (int b = 0; b < WORD_W; b++) if ((i * WORD_W + b) < TOTAL) w[b] = 1'b1;
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(string name, logic [BIG-1:0] act, logic [BIG-1:0] exp);
    int first;
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      first = -1;
      for (int b = BIG - 1; b >= 0; b--) if (act[b] !== exp[b]) first = b;
      $display("[TB] FAIL %s: first bad bit %0d, got word %08h, want word %08h",
               name, first, act[(first / 32) * 32 +: 32], exp[(first / 32) * 32 +: 32]);
    end
  endtask

  // Pops the oldest expected outcome and compares every output against it
  task automatic checkOutput(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s scoreboard: got empty queue, want an entry", tag);
      return;
    end
    e = sb.pop_front();
    check_val($sformatf("%s done", tag), 64'(done), 64'(e.done));
    check_val($sformatf("%s error", tag), 64'(error), 64'(e.error));
    check_val($sformatf("%s cfg_valid", tag), 64'(cfg_valid), 64'(e.valid));
    check_val($sformatf("%s busy", tag), 64'(busy), 64'd0);
    check_val($sformatf("%s in_ready", tag), 64'(in_ready), 64'd0);
    check_wide($sformatf("%s brbselect", tag), BIG'(brbselect), BIG'(e.cfg[BRB_W-1:0]));
    check_wide($sformatf("%s bsbselect", tag), BIG'(bsbselect), BIG'(e.cfg[BRB_W +: BSB_W]));
    check_wide($sformatf("%s lbselect", tag), BIG'(lbselect), BIG'(e.cfg[BRB_W+BSB_W +: LB_W]));
    check_wide($sformatf("%s leftio", tag), BIG'(leftioselect),
               BIG'(e.cfg[BRB_W+BSB_W+LB_W +: IO_W]));
    check_wide($sformatf("%s rightio", tag), BIG'(rightioselect),
               BIG'(e.cfg[BRB_W+BSB_W+LB_W+IO_W +: IO_W]));
    check_wide($sformatf("%s topio", tag), BIG'(topioselect),
               BIG'(e.cfg[BRB_W+BSB_W+LB_W+2*IO_W +: IO_W]));
    check_wide($sformatf("%s bottomio", tag), BIG'(bottomioselect),
               BIG'(e.cfg[BRB_W+BSB_W+LB_W+3*IO_W +: IO_W]));
  endtask

  task automatic push_expect(bit d, bit er);
    exp_t e;
    e.done  = d;
    e.error = er;
    e.valid = model_valid;
    e.cfg   = model_cfg;
    sb.push_back(e);
  endtask

  // Runs one full load described by vector v, recording its expected outcome
  task automatic applyStimulus(int v);
    vec_t              t;
    logic [WORD_W-1:0] words [NWORDS+1];
    logic [TOTAL-1:0]  img;
    logic [WORD_W-1:0] cs;
    int                i;
    int                xfers;
    int                guard;
    bit                xf;
    t   = vecs[v];
    cs  = '0;
    img = '0;
    for (int w = 0; w < NWORDS; w++) begin
      words[w] = gen_word(t.pattern, w);
      cs = cs ^ words[w];
      for (int b = 0; b < WORD_W; b++)
        if ((w * WORD_W + b) < TOTAL) img[w * WORD_W + b] = words[w][b];
    end
    words[NWORDS] = cs ^ t.flip;
    if (t.exp_done) begin
      model_cfg   = img;
      model_valid = 1'b1;
    end
    push_expect(t.exp_done, t.exp_error);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_val($sformatf("v%0d busy after start", v), 64'(busy), 64'd1);
    check_val($sformatf("v%0d done after start", v), 64'(done), 64'd0);
    check_val($sformatf("v%0d error after start", v), 64'(error), 64'd0);

    i = 0;
    xfers = 0;
    guard = 0;
    while (i <= NWORDS && guard < 20000) begin
      guard++;
      if (t.abort_at == i) begin
        abort    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = words[i];
        tick();
        abort    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        break;
      end
      in_valid = t.gappy ? ($urandom_range(0, 99) < 30) : 1'b1;
      start    = t.gappy ? ($urandom_range(0, 99) < 5) : 1'b0;
      in_data  = in_valid ? words[i] : WORD_W'($urandom);
      xf       = in_valid && in_ready;
      tick();
      if (xf) begin
        xfers++;
        i++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (guard >= 20000) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL v%0d timeout: got %0d words, want %0d", v, i, NWORDS + 1);
    end
    if (t.gappy) check_val($sformatf("v%0d transfers", v), 64'(xfers), 64'(NWORDS + 1));
    checkOutput($sformatf("v%0d", v));
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    model_cfg   = '0;
    model_valid = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;

    //             pattern flip   abort_at gappy done error
    vecs[0] = '{0, 8'h00, -1,     1'b0, 1'b1, 1'b0};
    vecs[1] = '{1, 8'h00, -1,     1'b0, 1'b1, 1'b0};
    vecs[2] = '{2, 8'h01, -1,     1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 8'h00, 100,    1'b0, 1'b0, 1'b1};
    vecs[4] = '{2, 8'h00, NWORDS, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2, 8'h00, -1,     1'b0, 1'b1, 1'b0};
    vecs[6] = '{0, 8'h00, -1,     1'b1, 1'b1, 1'b0};

    // Reset state, checked while rst_n is still asserted
    #2;
    push_expect(1'b0, 1'b0);
    checkOutput("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(v);
      if (vecs[v].pattern == 0 && vecs[v].exp_done)
        check_val($sformatf("v%0d brb[15:0]", v), 64'(brbselect[15:0]), 64'h0100);
    end

    // Stall with in_valid low, then reset partway through a reload
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_val("stall in_ready", 64'(in_ready), 64'd1);
    check_val("stall busy", 64'(busy), 64'd1);
    for (int w = 0; w < 200; w++) begin
      in_valid = 1'b1;
      in_data  = gen_word(1, w);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n       = 1'b0;
    #1;
    model_cfg   = '0;
    model_valid = 1'b0;
    push_expect(1'b0, 1'b0);
    checkOutput("midload reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post reset in_ready", 64'(in_ready), 64'd0);

    // Recovery after reset
    applyStimulus(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
